msk_dds_ctrl: RTL and testbench
===============================

MSK_DDS_CTRL -- requirements
Module: msk_dds_ctrl

Interface
REQ-001 Parameters (name, default, meaning) SHALL be:
- PINC_DEFAULT, 2684354, phase increment written after reset.
- PHASE_PI, 134217728, phase-offset word for pi (2^27 of a 28-bit accumulator).
- SYM_CYCLES, 16, clocks per symbol slot, legal range 2..65535.
- ADDR_PINC, 5'd0, DDS phase-increment register address.
- ADDR_POFF, 5'd16, DDS phase-offset register address.

REQ-002 Ports (name, direction, width, meaning) SHALL be:
- clk, in, 1, the single clock.
- reset, in, 1, asynchronous active-low reset.
- sym_valid, in, 1, a symbol is offered.
- sym_i, in, 1, I bit of the offered symbol.
- sym_q, in, 1, Q bit of the offered symbol.
- sym_ready, out, 1, the controller can accept a symbol.
- freq_req, in, 1, level request to load a new phase increment.
- freq_word, in, 28, new phase increment; held stable until freq_ack.
- freq_ack, out, 1, one-cycle pulse when freq_word is written.
- dds_addr, out, 5, DDS config address, shared by both cores.
- dds_data_sin, out, 28, config data for the sine core.
- dds_data_cos, out, 28, config data for the cosine core.
- dds_we, out, 1, config write strobe, shared by both cores.
- underrun, out, 1, one-cycle pulse when a slot expires with no symbol pending.

Function
REQ-003 All outputs SHALL be registered, and every DDS write SHALL last exactly one cycle with dds_we=1.
REQ-004 The FSM SHALL have the states INIT, IDLE, WR_SYM and WR_FREQ.
REQ-005 The first clock after reset release SHALL be in INIT and perform the write addr=ADDR_PINC, sin=cos=PINC_DEFAULT; the next state SHALL be IDLE.
REQ-006 sym_ready SHALL be 1 only in IDLE when the slot counter is 0.
REQ-007 On a handshake (sym_valid & sym_ready), the FSM SHALL enter WR_SYM, which performs the write addr=ADDR_POFF, sin=sym_i?PHASE_PI:0, cos=sym_q?PHASE_PI:0, then returns to IDLE.
REQ-008 On a handshake, the slot counter SHALL load SYM_CYCLES-1 and decrement by 1 per clock to 0, saturating there.
- The counter runs in every state, including WR_FREQ.
- Therefore consecutive accepted symbols are spaced exactly SYM_CYCLES clocks apart.
REQ-009 In IDLE with freq_req=1 and no handshake that cycle, the FSM SHALL enter WR_FREQ, which performs the write addr=ADDR_PINC, sin=cos=freq_word and asserts freq_ack for that same cycle; the next state SHALL be IDLE.
REQ-010 On a simultaneous handshake and freq_req, the symbol SHALL win; the frequency write SHALL follow immediately after WR_SYM if freq_req is still high.
REQ-011 freq_req SHALL be ignored in INIT, WR_SYM and WR_FREQ; a request held high after freq_ack SHALL cause another write, so the requester drops freq_req on freq_ack.
REQ-012 underrun SHALL pulse for one cycle on the first cycle the counter is 0 in IDLE with sym_valid=0, and only once per expired slot.
- Before the first symbol after reset, no underrun is flagged.
- With no writes issued, the DDS keeps its last offset.
REQ-013 Outside write cycles, dds_we SHALL be 0 and dds_addr and both data buses SHALL hold their last driven values.
REQ-014 A freq_word of 0 SHALL be written unchanged; all data SHALL be treated as unsigned 28-bit with no arithmetic applied.

Reset
REQ-015 While reset=0, the outputs SHALL be:
- dds_we=0, dds_addr=ADDR_PINC, dds_data_sin=dds_data_cos=PINC_DEFAULT.
- sym_ready=0, freq_ack=0, underrun=0.
- slot counter=0, state=INIT.
REQ-016 Reset asserted mid-write SHALL clear dds_we asynchronously; after release, the INIT write SHALL repeat.

Structure
REQ-017 The default values of PINC_DEFAULT, PHASE_PI, ADDR_PINC and ADDR_POFF, plus the FSM state encodings, SHALL live in a shared constants package (msk_dds_pkg) that is also used by the DDS wrapper.
REQ-018 The slot counter, including the first-symbol flag and underrun generation, SHALL be the sub-module msk_sym_timer; the FSM and write mux stay in msk_dds_ctrl.

Verification
REQ-019 The bench SHALL cover these directed scenarios:
- Reset release -> one write at cycle 1 (addr 0, both data 2684354, we=1), then sym_ready=1 from cycle 2.
- Symbols (i,q)=(1,0),(0,1),(1,1) with sym_valid held high -> writes at addr 16 with (sin,cos) = (134217728,0), (0,134217728), (134217728,134217728), spaced 16 cycles apart, no underrun.
- freq_req with freq_word=5368709 in idle -> one write (addr 0, both data 5368709) with freq_ack in the same cycle; slot timing unaffected.
- freq_req and a handshake in the same cycle -> WR_SYM write then WR_FREQ write on consecutive cycles, one freq_ack.
- sym_valid dropped after one symbol -> underrun pulses exactly once 16 cycles after the handshake, with no DDS writes.
- reset pulled low during a WR_SYM cycle -> dds_we falls without a clock edge; after release, the INIT write repeats.

Source files
------------

// File: rtl/msk_dds_pkg.sv
// Shared constants and state encoding for the MSK DDS configuration path.
// Used by the controller, the symbol timer and the DDS wrapper.
package msk_dds_pkg;

   localparam int unsigned DDS_W  = 28;
   localparam int unsigned ADDR_W = 5;
   localparam int unsigned CNT_W  = 16;

   localparam logic [DDS_W-1:0]  DEF_PINC      = 28'd2684354;
   localparam logic [DDS_W-1:0]  DEF_PHASE_PI  = 28'd134217728;
   localparam logic [ADDR_W-1:0] DEF_ADDR_PINC = 5'd0;
   localparam logic [ADDR_W-1:0] DEF_ADDR_POFF = 5'd16;

   typedef enum logic [1:0] {
      INIT    = 2'd0,
      IDLE    = 2'd1,
      WR_SYM  = 2'd2,
      WR_FREQ = 2'd3
   } dds_state_e;

   // A symbol bit selects either zero phase offset or pi.
   function automatic logic [DDS_W-1:0] phase_sel(input logic          bit_v,
                                                  input logic [DDS_W-1:0] pi_word);
      return bit_v ? pi_word : '0;
   endfunction

endpackage

// File: rtl/msk_sym_timer.sv
// Symbol slot counter: reloads on each accepted symbol, counts down to zero,
// and flags a single underrun when an armed slot expires with nothing offered.
module msk_sym_timer
   import msk_dds_pkg::*;
#(
   parameter int unsigned SYM_CYCLES = 16
) (
   input  logic clk,
   input  logic rst_n,
   input  logic load,
   input  logic in_idle,
   input  logic sym_valid,
   output logic cnt_zero_nxt,
   output logic underrun
);

   logic [CNT_W-1:0] cnt;
   logic [CNT_W-1:0] cnt_nxt;
   logic             armed;
   logic             flagged;
   logic             expire;

   always_comb begin
      cnt_nxt = cnt;
      if (load)
         cnt_nxt = CNT_W'(SYM_CYCLES - 1);
      else if (cnt != '0)
         cnt_nxt = cnt - 1'b1;
   end

   assign cnt_zero_nxt = (cnt_nxt == '0);

   // armed stays low until the first symbol, so a fresh reset never underruns.
   assign expire = in_idle && (cnt == '0) && !sym_valid && armed && !flagged;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt      <= '0;
         armed    <= 1'b0;
         flagged  <= 1'b0;
         underrun <= 1'b0;
      end else begin
         cnt      <= cnt_nxt;
         underrun <= expire;
         if (load) begin
            armed   <= 1'b1;
            flagged <= 1'b0;
         end else if (expire) begin
            flagged <= 1'b1;
         end
      end
   end

endmodule

// File: rtl/msk_dds_ctrl.sv
// MSK DDS configuration controller: programs the phase increment at start-up
// and on request, and writes per-symbol phase offsets to the sine/cosine cores.
module msk_dds_ctrl
   import msk_dds_pkg::*;
#(
   parameter logic [DDS_W-1:0]  PINC_DEFAULT = DEF_PINC,
   parameter logic [DDS_W-1:0]  PHASE_PI     = DEF_PHASE_PI,
   parameter int unsigned       SYM_CYCLES   = 16,
   parameter logic [ADDR_W-1:0] ADDR_PINC    = DEF_ADDR_PINC,
   parameter logic [ADDR_W-1:0] ADDR_POFF    = DEF_ADDR_POFF
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              sym_valid,
   input  logic              sym_i,
   input  logic              sym_q,
   output logic              sym_ready,
   input  logic              freq_req,
   input  logic [DDS_W-1:0]  freq_word,
   output logic              freq_ack,
   output logic [ADDR_W-1:0] dds_addr,
   output logic [DDS_W-1:0]  dds_data_sin,
   output logic [DDS_W-1:0]  dds_data_cos,
   output logic              dds_we,
   output logic              underrun
);

   dds_state_e        state;
   dds_state_e        state_nxt;
   logic              hs;
   logic              cnt_zero_nxt;
   logic              sym_i_q;
   logic              sym_q_q;
   logic              we_nxt;
   logic              ack_nxt;
   logic              ready_nxt;
   logic [ADDR_W-1:0] addr_nxt;
   logic [DDS_W-1:0]  sin_nxt;
   logic [DDS_W-1:0]  cos_nxt;

   assign hs = sym_valid && sym_ready;

   msk_sym_timer #(
      .SYM_CYCLES (SYM_CYCLES)
   ) u_timer (
      .clk          (clk),
      .rst_n        (reset),
      .load         (hs),
      .in_idle      (state == IDLE),
      .sym_valid    (sym_valid),
      .cnt_zero_nxt (cnt_zero_nxt),
      .underrun     (underrun)
   );

   always_ff @(posedge clk or negedge reset) begin
      if (!reset)
         state <= INIT;
      else
         state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      case (state)
         INIT:    state_nxt = IDLE;
         IDLE:    if (hs)            state_nxt = WR_SYM;
                  else if (freq_req) state_nxt = WR_FREQ;
         WR_SYM:  state_nxt = freq_req ? WR_FREQ : IDLE;
         WR_FREQ: state_nxt = IDLE;
         default: state_nxt = INIT;
      endcase
   end

   // Write registers decode the current state, so each write is visible the
   // cycle after its state; sym_ready looks ahead so slots stay SYM_CYCLES long.
   always_comb begin
      we_nxt    = 1'b0;
      ack_nxt   = 1'b0;
      addr_nxt  = dds_addr;
      sin_nxt   = dds_data_sin;
      cos_nxt   = dds_data_cos;
      ready_nxt = (state != INIT) && (state_nxt == IDLE) && cnt_zero_nxt;
      case (state)
         INIT: begin
            we_nxt   = 1'b1;
            addr_nxt = ADDR_PINC;
            sin_nxt  = PINC_DEFAULT;
            cos_nxt  = PINC_DEFAULT;
         end
         WR_SYM: begin
            we_nxt   = 1'b1;
            addr_nxt = ADDR_POFF;
            sin_nxt  = phase_sel(sym_i_q, PHASE_PI);
            cos_nxt  = phase_sel(sym_q_q, PHASE_PI);
         end
         WR_FREQ: begin
            we_nxt   = 1'b1;
            ack_nxt  = 1'b1;
            addr_nxt = ADDR_PINC;
            sin_nxt  = freq_word;
            cos_nxt  = freq_word;
         end
         default: ;
      endcase
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         dds_we       <= 1'b0;
         freq_ack     <= 1'b0;
         sym_ready    <= 1'b0;
         dds_addr     <= ADDR_PINC;
         dds_data_sin <= PINC_DEFAULT;
         dds_data_cos <= PINC_DEFAULT;
         sym_i_q      <= 1'b0;
         sym_q_q      <= 1'b0;
      end else begin
         dds_we       <= we_nxt;
         freq_ack     <= ack_nxt;
         sym_ready    <= ready_nxt;
         dds_addr     <= addr_nxt;
         dds_data_sin <= sin_nxt;
         dds_data_cos <= cos_nxt;
         if (hs) begin
            sym_i_q <= sym_i;
            sym_q_q <= sym_q;
         end
      end
   end

endmodule

// File: tb/tb_msk_dds_ctrl.sv
// Directed bench for msk_dds_ctrl: start-up write, symbol offsets, frequency
// updates, underrun and asynchronous reset during a write.
module tb_msk_dds_ctrl;

   logic        clk = 1'b0;
   logic        reset = 1'b0;
   logic        sym_valid = 1'b0;
   logic        sym_i = 1'b0;
   logic        sym_q = 1'b0;
   logic        freq_req = 1'b0;
   logic [27:0] freq_word = '0;
   logic        sym_ready;
   logic        freq_ack;
   logic [4:0]  dds_addr;
   logic [27:0] dds_data_sin;
   logic [27:0] dds_data_cos;
   logic        dds_we;
   logic        underrun;

   localparam logic [31:0] PINC0 = 32'd2684354;
   localparam logic [31:0] PI    = 32'd134217728;
   localparam logic [31:0] FW    = 32'd5368709;

   int total = 0;
   int bad   = 0;
   int n_we;
   int n_ur;

   always #5 clk = ~clk;

   msk_dds_ctrl #(
      .PINC_DEFAULT (28'd2684354),
      .PHASE_PI     (28'd134217728),
      .SYM_CYCLES   (16),
      .ADDR_PINC    (5'd0),
      .ADDR_POFF    (5'd16)
   ) dut (
      .clk          (clk),
      .reset        (reset),
      .sym_valid    (sym_valid),
      .sym_i        (sym_i),
      .sym_q        (sym_q),
      .sym_ready    (sym_ready),
      .freq_req     (freq_req),
      .freq_word    (freq_word),
      .freq_ack     (freq_ack),
      .dds_addr     (dds_addr),
      .dds_data_sin (dds_data_sin),
      .dds_data_cos (dds_data_cos),
      .dds_we       (dds_we),
      .underrun     (underrun)
   );

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
      end
   endtask

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   task automatic run(input int n);
      n_we = 0;
      n_ur = 0;
      repeat (n) begin
         tick();
         if (dds_we)   n_we++;
         if (underrun) n_ur++;
      end
   endtask

   task automatic chk_wr(input string tag, input logic [31:0] addr,
                         input logic [31:0] sin_v, input logic [31:0] cos_v);
      chk({tag, "_we"},   32'(dds_we),       32'd1);
      chk({tag, "_addr"}, 32'(dds_addr),     addr);
      chk({tag, "_sin"},  32'(dds_data_sin), sin_v);
      chk({tag, "_cos"},  32'(dds_data_cos), cos_v);
   endtask

   initial begin
      // reset state
      repeat (3) tick();
      chk("rst_we",    32'(dds_we),       32'd0);
      chk("rst_addr",  32'(dds_addr),     32'd0);
      chk("rst_sin",   32'(dds_data_sin), PINC0);
      chk("rst_cos",   32'(dds_data_cos), PINC0);
      chk("rst_ready", 32'(sym_ready),    32'd0);
      chk("rst_ack",   32'(freq_ack),     32'd0);
      chk("rst_ur",    32'(underrun),     32'd0);

      // INIT write, then ready
      reset = 1'b1;
      tick();
      chk_wr("init", 32'd0, PINC0, PINC0);
      chk("init_ready", 32'(sym_ready), 32'd0);
      tick();
      chk("c2_we",    32'(dds_we),    32'd0);
      chk("c2_ready", 32'(sym_ready), 32'd1);
      chk("c2_addr",  32'(dds_addr),  32'd0);

      // symbol (1,0)
      sym_valid = 1'b1; sym_i = 1'b1; sym_q = 1'b0;
      tick();
      chk("hs1_ready", 32'(sym_ready), 32'd0);
      chk("hs1_we",    32'(dds_we),    32'd0);
      sym_i = 1'b0; sym_q = 1'b1;
      tick();
      chk_wr("sym10", 32'd16, PI, 32'd0);
      chk("sym10_ack", 32'(freq_ack), 32'd0);
      run(13);
      chk("gap1_we",    32'(n_we),         32'd0);
      chk("gap1_ur",    32'(n_ur),         32'd0);
      chk("gap1_ready", 32'(sym_ready),    32'd0);
      chk("hold_addr",  32'(dds_addr),     32'd16);
      chk("hold_sin",   32'(dds_data_sin), PI);
      tick();
      chk("slot_ready", 32'(sym_ready), 32'd1);

      // symbol (0,1), exactly 16 cycles after the first
      tick();
      chk("hs2_ready", 32'(sym_ready), 32'd0);
      sym_i = 1'b1; sym_q = 1'b1;
      tick();
      chk_wr("sym01", 32'd16, 32'd0, PI);
      run(14);
      chk("gap2_we",    32'(n_we),      32'd0);
      chk("gap2_ur",    32'(n_ur),      32'd0);
      chk("gap2_ready", 32'(sym_ready), 32'd1);

      // symbol (1,1)
      tick();
      tick();
      chk_wr("sym11", 32'd16, PI, PI);

      // frequency update while idle mid-slot
      freq_req = 1'b1; freq_word = 28'd5368709;
      sym_i = 1'b0; sym_q = 1'b0;
      tick();
      chk("fq_pre_we",  32'(dds_we),   32'd0);
      chk("fq_pre_ack", 32'(freq_ack), 32'd0);
      tick();
      chk_wr("freq", 32'd0, FW, FW);
      chk("freq_ack", 32'(freq_ack), 32'd1);
      freq_req = 1'b0;
      tick();
      chk("fq_post_ack", 32'(freq_ack), 32'd0);
      chk("fq_post_we",  32'(dds_we),   32'd0);
      run(11);
      chk("gap3_we",    32'(n_we),      32'd0);
      chk("gap3_ready", 32'(sym_ready), 32'd1);
      tick();
      tick();
      chk_wr("sym00", 32'd16, 32'd0, 32'd0);

      // simultaneous handshake and frequency request, freq_word = 0
      sym_i = 1'b1; sym_q = 1'b0;
      run(14);
      chk("gap4_we",    32'(n_we),      32'd0);
      chk("gap4_ready", 32'(sym_ready), 32'd1);
      freq_req = 1'b1; freq_word = '0;
      tick();
      chk("both_we",  32'(dds_we),   32'd0);
      chk("both_ack", 32'(freq_ack), 32'd0);
      sym_valid = 1'b0;
      tick();
      chk_wr("both_sym", 32'd16, PI, 32'd0);
      chk("both_sym_ack", 32'(freq_ack), 32'd0);
      tick();
      chk_wr("both_freq", 32'd0, 32'd0, 32'd0);
      chk("both_freq_ack", 32'(freq_ack), 32'd1);
      freq_req = 1'b0;
      tick();
      chk("both_end_we",  32'(dds_we),   32'd0);
      chk("both_end_ack", 32'(freq_ack), 32'd0);

      // underrun 16 cycles after the last handshake, only once
      run(12);
      chk("ur_pre",       32'(n_ur),      32'd0);
      chk("ur_pre_we",    32'(n_we),      32'd0);
      chk("ur_pre_ready", 32'(sym_ready), 32'd1);
      tick();
      chk("ur_pulse", 32'(underrun), 32'd1);
      chk("ur_we",    32'(dds_we),   32'd0);
      tick();
      chk("ur_drop", 32'(underrun), 32'd0);
      run(10);
      chk("ur_once",    32'(n_ur),         32'd0);
      chk("ur_idle_we", 32'(n_we),         32'd0);
      chk("ur_hold",    32'(dds_data_sin), 32'd0);

      // asynchronous reset during a symbol write
      sym_valid = 1'b1; sym_i = 1'b0; sym_q = 1'b1;
      tick();
      sym_valid = 1'b0;
      tick();
      chk("mid_we_pre", 32'(dds_we), 32'd1);
      #2 reset = 1'b0;
      #1;
      chk("mid_we_async", 32'(dds_we),       32'd0);
      chk("mid_addr",     32'(dds_addr),     32'd0);
      chk("mid_sin",      32'(dds_data_sin), PINC0);
      tick();
      tick();
      chk("mid_hold_we", 32'(dds_we), 32'd0);
      reset = 1'b1;
      tick();
      chk_wr("reinit", 32'd0, PINC0, PINC0);
      tick();
      chk("reinit_ready", 32'(sym_ready), 32'd1);
      run(20);
      chk("first_ur", 32'(n_ur), 32'd0);
      chk("first_we", 32'(n_we), 32'd0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
